// File: rtl/fpu_operand_loader.sv
// Byte-serial loader that assembles FPU operands A and B, commits them as a pair and freezes them for HOLD_CYCLES.
// Optional trailing XOR checksum byte is compiled in with OPERAND_CHECKSUM_EN.
module fpu_operand_loader #(
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  output logic        ops_valid,
  output logic        busy,
  output logic [7:0]  pair_count,
  output logic        chk_err
);

  // A byte moves only on an edge where byte_valid and byte_ready are both high;
  // the producer holds byte_in stable while byte_valid is high and not yet accepted.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
`ifdef OPERAND_CHECKSUM_EN
    CHECK  = 2'd2,
`endif
    HOLD   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] shadow_a;
  logic [7:0]  hold_cnt;
  logic        xfer;
  logic        commit;

`ifdef OPERAND_CHECKSUM_EN
  logic [31:0] shadow_b;
  logic [7:0]  csum;
  logic        chk_fail;
  logic        chk_err_r;
`else
  // The final B byte is taken straight from byte_in at commit, so only three bytes are stored.
  logic [23:0] shadow_b;
`endif

  assign byte_ready = (state != HOLD);
  assign busy       = (state == HOLD);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clock100KHz) begin
    if (reset) state <= LOAD_A;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    commit     = 1'b0;
`ifdef OPERAND_CHECKSUM_EN
    chk_fail   = 1'b0;
`endif
    case (state)
      LOAD_A: if (xfer && byte_cnt == 2'd3) next_state = LOAD_B;
      LOAD_B: begin
        if (xfer && byte_cnt == 2'd3) begin
`ifdef OPERAND_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = HOLD;
          commit     = 1'b1;
`endif
        end
      end
`ifdef OPERAND_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (byte_in == csum) begin
            next_state = HOLD;
            commit     = 1'b1;
          end else begin
            next_state = LOAD_A;
            chk_fail   = 1'b1;
          end
        end
      end
`endif
      HOLD:    if (hold_cnt <= 8'd1) next_state = LOAD_A;
      default: next_state = LOAD_A;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      shadow_a   <= '0;
      shadow_b   <= '0;
      op_A_out   <= '0;
      op_B_out   <= '0;
      ops_valid  <= 1'b0;
      pair_count <= 8'd0;
      hold_cnt   <= 8'd0;
`ifdef OPERAND_CHECKSUM_EN
      csum       <= 8'd0;
      chk_err_r  <= 1'b0;
`endif
    end else begin
      ops_valid <= commit;
      if (xfer && (state == LOAD_A || state == LOAD_B)) byte_cnt <= byte_cnt + 2'd1;
      if (xfer && state == LOAD_A) shadow_a <= {shadow_a[23:0], byte_in};
`ifdef OPERAND_CHECKSUM_EN
      chk_err_r <= chk_fail;
      if (xfer && state == LOAD_B) shadow_b <= {shadow_b[23:0], byte_in};
      // Running XOR restarts after every checksum byte, good or bad.
      if (xfer && (state == LOAD_A || state == LOAD_B)) csum <= csum ^ byte_in;
      else if (xfer && state == CHECK) csum <= 8'd0;
`else
      if (xfer && state == LOAD_B) shadow_b <= {shadow_b[15:0], byte_in};
`endif
      if (commit) begin
        op_A_out   <= shadow_a;
`ifdef OPERAND_CHECKSUM_EN
        op_B_out   <= shadow_b;
`else
        op_B_out   <= {shadow_b, byte_in};
`endif
        pair_count <= pair_count + 8'd1;
        hold_cnt   <= 8'(HOLD_CYCLES);
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

`ifdef OPERAND_CHECKSUM_EN
  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader: default-hold instance plus a HOLD_CYCLES=1 instance for pair_count wrap.
module tb_fpu_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] op_A_out, op_B_out;
  logic        ops_valid, busy, chk_err;
  logic [7:0]  pair_count;

  logic [7:0]  w_byte_in;
  logic        w_byte_valid, w_byte_ready;
  logic [31:0] w_op_A_out, w_op_B_out;
  logic        w_ops_valid, w_busy, w_chk_err;
  logic [7:0]  w_pair_count;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses = 0, busy_cycles = 0, hold_accepts = 0, chk_pulses = 0, w_pulses = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_operand_loader dut (
    .clock100KHz(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .op_A_out(op_A_out), .op_B_out(op_B_out),
    .ops_valid(ops_valid), .busy(busy), .pair_count(pair_count), .chk_err(chk_err)
  );

  fpu_operand_loader #(.HOLD_CYCLES(1)) dut_w (
    .clock100KHz(clk), .reset(reset), .byte_in(w_byte_in), .byte_valid(w_byte_valid),
    .byte_ready(w_byte_ready), .op_A_out(w_op_A_out), .op_B_out(w_op_B_out),
    .ops_valid(w_ops_valid), .busy(w_busy), .pair_count(w_pair_count), .chk_err(w_chk_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] xor8(input logic [31:0] a, input logic [31:0] b);
    return a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction

  // Scoreboard and event counters, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (!reset) begin
      if (busy) busy_cycles++;
      if (busy && byte_valid && byte_ready) hold_accepts++;
      if (chk_err) chk_pulses++;
      if (w_ops_valid) w_pulses++;
      if (ops_valid) begin
        pulses++;
        if (exp_q.size() == 0) check("ops_valid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_pair", {op_A_out, op_B_out}, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
    exp_q.push_back({a, b});
    send_word(a, gap);
    send_word(b, gap);
`ifdef OPERAND_CHECKSUM_EN
    send_byte(xor8(a, b), gap);
`endif
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!byte_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    byte_valid = 1'b0;
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic w_send_byte(input logic [7:0] b);
    int n;
    w_byte_in    = b;
    w_byte_valid = 1'b1;
    n = 0;
    while (!w_byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("w_send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    logic [7:0]  p8;
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
    w_byte_in = 8'h00; w_byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_op_a", op_A_out, 0);
    check("rst_op_b", op_B_out, 0);
    check("rst_ops_valid", ops_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pair_count", pair_count, 0);
    check("rst_byte_ready", byte_ready, 1);
    check("rst_chk_err", chk_err, 0);

    // Basic back-to-back load.
    pulses = 0; busy_cycles = 0;
    exp_q.push_back({32'h3F800000, 32'h40000000});
    send_word(32'h3F800000, 0);
    check("no_early_a", op_A_out, 0);
    send_word(32'h40000000, 0);
`ifdef OPERAND_CHECKSUM_EN
    send_byte(8'hFF, 0);
`endif
    byte_valid = 1'b0;
    check("commit_ops_valid", ops_valid, 1);
    check("commit_busy", busy, 1);
    check("commit_op_a", op_A_out, 32'h3F800000);
    check("commit_op_b", op_B_out, 32'h40000000);
    check("commit_pair_count", pair_count, 1);
    @(posedge clk); #1;
    check("ops_valid_one_cycle", ops_valid, 0);
    wait_idle(n);
    check("basic_busy_cycles", busy_cycles, 64);
    check("basic_pulses", pulses, 1);

    // Gapped stream, byte_valid held high through HOLD.
    pulses = 0; busy_cycles = 0; hold_accepts = 0;
    send_pair(32'h3F800000, 32'h40000000, 3);
    byte_in = 8'hEE; byte_valid = 1'b1;
    wait_idle(n);
    check("stall_hold_len", n, 64);
    check("stall_hold_accepts", hold_accepts, 0);
    check("stall_op_a", op_A_out, 32'h3F800000);
    check("stall_op_b", op_B_out, 32'h40000000);
    check("stall_pair_count", pair_count, 2);
    check("stall_pulses", pulses, 1);

    // Reset after 5 accepted bytes, with a byte offered on the reset edge.
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    check("partial_op_a", op_A_out, 32'h3F800000);
    check("partial_op_b", op_B_out, 32'h40000000);
    reset = 1'b1; byte_in = 8'h99; byte_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; byte_valid = 1'b0;
    check("midrst_op_a", op_A_out, 0);
    check("midrst_op_b", op_B_out, 0);
    check("midrst_pair_count", pair_count, 0);
    check("midrst_byte_ready", byte_ready, 1);
    check("midrst_busy", busy, 0);
    send_pair(32'hC0490FDB, 32'h3E99999A, 1);
    check("fresh_op_a", op_A_out, 32'hC0490FDB);
    check("fresh_op_b", op_B_out, 32'h3E99999A);
    check("fresh_pair_count", pair_count, 1);
    wait_idle(n);

`ifdef OPERAND_CHECKSUM_EN
    // Good checksum commits; bad checksum pulses chk_err and changes nothing.
    chk_pulses = 0;
    send_pair(32'h3F800000, 32'h40000000, 0);
    check("cs_good_pair_count", pair_count, 2);
    wait_idle(n);
    send_word(32'h3F800000, 0);
    send_word(32'h40000000, 0);
    send_byte(8'hFE, 0);
    byte_valid = 1'b0;
    check("cs_bad_chk_err", chk_err, 1);
    @(posedge clk); #1;
    check("cs_bad_chk_err_drop", chk_err, 0);
    check("cs_bad_pulses", chk_pulses, 1);
    check("cs_bad_op_a", op_A_out, 32'h3F800000);
    check("cs_bad_op_b", op_B_out, 32'h40000000);
    check("cs_bad_pair_count", pair_count, 2);
    check("cs_bad_ready", byte_ready, 1);
`else
    check("chk_err_quiet", chk_pulses, 0);
`endif

    // 256 pairs on the HOLD_CYCLES=1 instance.
    w_pulses = 0;
    a = 32'h0; b = 32'h0;
    for (int p = 0; p < 256; p++) begin
      p8 = 8'(p);
      a = {p8, ~p8, 8'hA5, p8};
      b = {8'h5A, p8, ~p8, p8};
      for (int i = 0; i < 4; i++) w_send_byte(a[31-8*i -: 8]);
      for (int i = 0; i < 4; i++) w_send_byte(b[31-8*i -: 8]);
`ifdef OPERAND_CHECKSUM_EN
      w_send_byte(xor8(a, b));
`endif
      w_byte_valid = 1'b0;
      if (p == 254) check("wrap_count_255", w_pair_count, 255);
    end
    @(posedge clk); #1;
    check("wrap_count_0", w_pair_count, 0);
    check("wrap_pulses", w_pulses, 256);
    check("wrap_last_a", w_op_A_out, a);
    check("wrap_last_b", w_op_B_out, b);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_operand_loader.md
FPU_OPERAND_LOADER -- requirements
Module: fpu_operand_loader

Interface
REQ-001 Parameter: HOLD_CYCLES, default 64, number of cycles committed operands stay frozen before the next load; legal range 1..255.
REQ-002 Port: clock100KHz  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: byte_in  input  8  operand byte stream, most significant byte first.
REQ-005 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-006 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-007 Port: op_A_out  output  32  committed operand A, wired to the FPU operand-A input.
REQ-008 Port: op_B_out  output  32  committed operand B, wired to the FPU operand-B input.
REQ-009 Port: ops_valid  output  1  one-cycle pulse when a new operand pair is committed.
REQ-010 Port: busy  output  1  high while in HOLD.
REQ-011 Port: pair_count  output  8  number of committed pairs, wrapping 255->0.
REQ-012 Port: chk_err  output  1  one-cycle pulse on checksum mismatch (only with OPERAND_CHECKSUM_EN).

Function
REQ-013 The loader SHALL have states LOAD_A, LOAD_B, CHECK (compiled only with OPERAND_CHECKSUM_EN) and HOLD.
REQ-014 A byte transfer SHALL occur only on a rising edge where byte_valid and byte_ready are both 1.
REQ-015 byte_ready SHALL be 1 in LOAD_A, LOAD_B and CHECK, and 0 in HOLD; byte_valid in HOLD SHALL be ignored.
REQ-016 LOAD_A SHALL shift 4 bytes into a shadow A register (first byte -> bits 31:24), then go to LOAD_B.
REQ-017 LOAD_B SHALL shift 4 bytes into a shadow B register in the same order, then go to CHECK if compiled, else commit.
REQ-018 Commit SHALL, on the edge that accepts the final byte, load op_A_out/op_B_out from the shadows, increment pair_count, and enter HOLD.
REQ-019 ops_valid SHALL be 1 for exactly the one cycle following the commit edge.
REQ-020 op_A_out and op_B_out SHALL change only at commit or reset, never during partial loads.
REQ-021 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by an 8-bit down-counter, then go to LOAD_A.
REQ-022 Gaps (byte_valid=0) SHALL stall the current state with no timeout and no loss of already accepted bytes.
REQ-023 pair_count SHALL wrap from 255 to 0 without a flag.

Reset
REQ-024 While reset=1 on an edge: state=LOAD_A, shadows=0, op_A_out=0, op_B_out=0, ops_valid=0, busy=0, pair_count=0, chk_err=0, HOLD counter=0.
REQ-025 Reset mid-load or mid-HOLD SHALL discard partial bytes; byte_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-026 Reset SHALL take priority over a simultaneous byte transfer.

Configuration
REQ-027 Macro OPERAND_CHECKSUM_EN defined: after 8 bytes the loader SHALL enter CHECK and accept a 9th byte; if it equals the XOR of the 8 operand bytes it SHALL commit, otherwise it SHALL pulse chk_err for one cycle, leave outputs and pair_count unchanged, and return to LOAD_A.
REQ-028 Macro OPERAND_CHECKSUM_EN undefined: the CHECK state SHALL not exist, the commit SHALL occur on the 8th byte, and chk_err SHALL be tied to 0.

Verification
REQ-029 Basic load (no macro): bytes 3F 80 00 00 40 00 00 00 back-to-back -> op_A_out=0x3F800000, op_B_out=0x40000000, ops_valid pulses once, pair_count=1, busy=1 for 64 cycles.
REQ-030 Stall/HOLD: same stream with byte_valid=0 gaps of 3 cycles, plus byte_valid=1 during HOLD -> identical outputs; no byte accepted while busy=1; byte_ready returns after exactly HOLD_CYCLES.
REQ-031 Reset mid-load: reset after 5 accepted bytes -> outputs 0, pair_count=0; a fresh 8-byte stream then commits correctly.
REQ-032 Checksum (macro on): stream plus checksum FF -> commit. The same stream with checksum FE -> chk_err pulse, op_A_out/op_B_out unchanged, pair_count unchanged.
REQ-033 Wrap: 256 consecutive pairs with HOLD_CYCLES=1 -> pair_count returns to 0; each pair produces exactly one ops_valid pulse.
